// File: rtl/prewish_mask_blinker_pkg.sv
// Shared types and constants for the mask blinker: state encoding, mask width,
// default prescale and the wrapping bit-index step.
package prewish_mask_blinker_pkg;

  typedef enum logic {
    PW_IDLE = 1'b0,
    PW_RUN  = 1'b1
  } pw_state_e;

  localparam int MASK_W           = 8;
  localparam int TICK_DIV_DEFAULT = 3_000_000;

  // Playback runs MSB first; index 0 wraps back to 7.
  function automatic logic [2:0] next_idx(input logic [2:0] idx);
    return idx - 3'd1;
  endfunction

endpackage

// File: rtl/prewish_mask_blinker_tick_gen.sv
// Prescaler: 1-cycle TICK_O on terminal count while enabled; a clear restarts the
// count at 0 and suppresses the tick in that cycle.
module prewish_tick_gen #(
  parameter int TICK_DIV = 3_000_000
) (
  input  logic CLK_I,
  input  logic RST_I,
  input  logic CLR_I,
  input  logic EN_I,
  output logic TICK_O
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] ONE  = PW'(1);

  logic [PW-1:0] presc;

  always_ff @(posedge CLK_I) begin
    if (RST_I || CLR_I || !EN_I) presc <= '0;
    else if (presc == LAST)      presc <= '0;
    else                         presc <= presc + ONE;
  end

  assign TICK_O = EN_I && !CLR_I && (presc == LAST);

endmodule

// File: rtl/prewish_mask_blinker.sv
// Plays an 8-bit blink mask on one LED, MSB first, one bit per TICK_DIV cycles,
// looping until a new mask is strobed in. All outputs are registered.
module prewish_mask_blinker
  import prewish_mask_blinker_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic              CLK_I,
  input  logic              RST_I,
  input  logic              STB_I,
  input  logic [MASK_W-1:0] DAT_I,
  output logic              ACK_O,
  output logic              LED_O,
  output logic              BUSY_O,
  output logic              WRAP_O
);

  pw_state_e         state_q, state_d;
  logic              stb_d;
  logic              load;
  logic              tick;
  logic [MASK_W-1:0] mask_reg;
  logic [2:0]        bit_idx;
  logic [2:0]        nidx;
  logic              ack, led, busy, wrap;

  // A held strobe loads only once; it must drop before the next load.
  assign load = STB_I && !stb_d;
  assign nidx = next_idx(bit_idx);

  prewish_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .CLK_I  (CLK_I),
    .RST_I  (RST_I),
    .CLR_I  (load),
    .EN_I   (state_q == PW_RUN),
    .TICK_O (tick)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      PW_IDLE: if (load) state_d = PW_RUN;
      PW_RUN:  state_d = PW_RUN;
      default: state_d = PW_IDLE;
    endcase
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q  <= PW_IDLE;
      stb_d    <= 1'b0;
      mask_reg <= '0;
      bit_idx  <= 3'd7;
      ack      <= 1'b0;
      led      <= 1'b0;
      busy     <= 1'b0;
      wrap     <= 1'b0;
    end else begin
      state_q <= state_d;
      stb_d   <= STB_I;
      ack     <= load;
      busy    <= (state_d == PW_RUN);
      wrap    <= 1'b0;
      if (load) begin
        mask_reg <= DAT_I;
        bit_idx  <= 3'd7;
        led      <= DAT_I[MASK_W-1];
      end else if (state_q == PW_RUN) begin
        if (tick) begin
          bit_idx <= nidx;
          led     <= mask_reg[nidx];
          wrap    <= (bit_idx == 3'd0);
        end
      end else begin
        led <= 1'b0;
      end
    end
  end

  assign ACK_O  = ack;
  assign LED_O  = led;
  assign BUSY_O = busy;
  assign WRAP_O = wrap;

endmodule

// File: tb/tb_prewish_mask_blinker.sv
// Randomized + directed bench for prewish_mask_blinker (TICK_DIV=4) with a
// per-cycle scoreboard fed by a time-since-load reference model.
module tb_prewish_mask_blinker;

  localparam int TD = 4;

  logic       CLK_I = 1'b0;
  logic       RST_I = 1'b1;
  logic       STB_I = 1'b0;
  logic [7:0] DAT_I = 8'h00;
  logic       ACK_O, LED_O, BUSY_O, WRAP_O;

  prewish_mask_blinker #(.TICK_DIV(TD)) dut (
    .CLK_I  (CLK_I),
    .RST_I  (RST_I),
    .STB_I  (STB_I),
    .DAT_I  (DAT_I),
    .ACK_O  (ACK_O),
    .LED_O  (LED_O),
    .BUSY_O (BUSY_O),
    .WRAP_O (WRAP_O)
  );

  always #5 CLK_I = ~CLK_I;

  // Reference state: whether a mask is playing and cycles elapsed since its load.
  logic       m_run  = 1'b0;
  logic       m_prev = 1'b0;
  logic [7:0] m_mask = 8'h00;
  int         m_t    = 0;
  int         cyc    = 0;

  logic [3:0] exp_q[$];  // {ack, led, busy, wrap}
  int tests = 0;
  int fails = 0;

  task automatic step(input logic r, input logic s, input logic [7:0] d);
    logic       ld;
    logic [3:0] e;
    int         bitpos;
    RST_I = r; STB_I = s; DAT_I = d;
    ld = 1'b0;
    if (r) begin
      m_run = 1'b0; m_prev = 1'b0; m_t = 0;
      e = 4'b0000;
    end else begin
      ld = s && !m_prev;
      m_prev = s;
      if (ld) begin
        m_run = 1'b1; m_mask = d; m_t = 0;
      end else if (m_run) begin
        m_t++;
      end
      if (m_run) begin
        bitpos = 7 - ((m_t / TD) % 8);
        e = {ld, m_mask[bitpos], 1'b1, (!ld && m_t > 0 && (m_t % (8*TD)) == 0)};
      end else begin
        e = 4'b0000;
      end
    end
    @(posedge CLK_I);
    exp_q.push_back(e);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, $urandom_range(0, 255));
  endtask

  always @(negedge CLK_I) begin
    logic [3:0] e, a;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {ACK_O, LED_O, BUSY_O, WRAP_O};
      tests++;
      if (a !== e) begin
        fails++;
        $display("FAIL outputs cyc%0d {ack,led,busy,wrap} got %b exp %b", cyc, a, e);
      end
    end
  end

  initial begin
    // 1. reset 3 cycles, then A5 playing
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b1, 8'hFF);
    step(1'b1, 1'b0, 8'h00);
    idle(2);
    step(1'b0, 1'b1, 8'hA5);
    // 2. two full loops plus a bit
    step(1'b0, 1'b0, 8'h00);
    idle(70);
    // 3. held strobe with changing data
    step(1'b0, 1'b1, 8'h0F);
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1, $urandom_range(0, 255));
    idle(30);
    // 4. mid-pattern reload during bit 4 of A5
    step(1'b0, 1'b1, 8'hA5);
    idle(13);
    step(1'b0, 1'b1, 8'h80);
    idle(40);
    // 5. reset coincident with a strobe rise mid-run
    step(1'b0, 1'b1, 8'hFF);
    idle(9);
    step(1'b1, 1'b1, 8'hFF);
    step(1'b0, 1'b1, 8'hFF);
    idle(10);
    // 6. zero mask still runs and wraps; then solid FF
    step(1'b0, 1'b1, 8'h00);
    idle(70);
    step(1'b0, 1'b1, 8'hFF);
    idle(40);
    // randomized episodes
    for (int ep = 0; ep < 60; ep++) begin
      if ($urandom_range(0, 19) == 0) begin
        for (int i = 0; i < int'($urandom_range(1, 3)); i++)
          step(1'b1, 1'(($urandom_range(0, 1))), $urandom_range(0, 255));
      end else begin
        for (int i = 0; i < int'($urandom_range(1, 3)); i++)
          step(1'b0, 1'b1, $urandom_range(0, 255));
      end
      idle($urandom_range(0, 70));
    end
    step(1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge CLK_I);
    @(posedge CLK_I);
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain got %0d pending exp 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
